// File: rtl/data_mem_ctrl.sv
// Byte-addressable big-endian data memory for the MEM stage: request/response
// handshake, programmable wait states, and rejection of illegal accesses.
module data_mem_ctrl #(
   parameter int DEPTH       = 64,
   parameter int WAIT_CYCLES = 0
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_write,
   input  logic [1:0]  req_size,
   input  logic        req_signed,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        resp_valid,
   input  logic        resp_ready,
   output logic [31:0] resp_rdata,
   output logic        resp_err
);
   localparam int AW = $clog2(DEPTH);

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

   typedef struct packed {
      logic          write;
      logic [1:0]    size;
      logic          sgn;
      logic          err;
      logic [AW-1:0] addr;
      logic [31:0]   wdata;
   } req_t;

   state_t     state;
   req_t       cur;
   logic [3:0] cnt;
   logic [7:0] mem [DEPTH];

   // last byte touched, one bit wider so running off the top shows in the MSB
   logic [AW:0] last;
   logic        req_err;

   always_comb begin
      last = {1'b0, req_addr[AW-1:0]};
      case (req_size)
         2'b01:   last = last + (AW+1)'(1);
         2'b10:   last = last + (AW+1)'(3);
         default: ;
      endcase
      req_err = (req_size == 2'b11) ||
                (req_size == 2'b01 && req_addr[0]) ||
                (req_size == 2'b10 && req_addr[1:0] != 2'b00) ||
                (req_addr[31:AW] != '0) || last[AW];
   end

   logic [AW-1:0] a1, a2, a3;
   logic [7:0]    b0, b1, b2, b3;
   logic          ext;
   logic [31:0]   ld;

   always_comb begin
      a1  = cur.addr + AW'(1);
      a2  = cur.addr + AW'(2);
      a3  = cur.addr + AW'(3);
      b0  = mem[cur.addr];
      b1  = mem[a1];
      b2  = mem[a2];
      b3  = mem[a3];
      ext = cur.sgn & b0[7];
      case (cur.size)
         2'b00:   ld = {{24{ext}}, b0};
         2'b01:   ld = {{16{ext}}, b0, b1};
         default: ld = {b0, b1, b2, b3};
      endcase
   end

   // Errors still pass through WAIT with a zero count, so they answer one
   // cycle after acceptance, the same as a zero-wait access.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state      <= S_IDLE;
         req_ready  <= 1'b1;
         resp_valid <= 1'b0;
         resp_rdata <= '0;
         resp_err   <= 1'b0;
         cnt        <= '0;
         cur        <= '0;
         for (int i = 0; i < DEPTH; i++) mem[i] <= 8'(i);
      end else begin
         case (state)
            S_IDLE: if (req_valid) begin
               cur <= '{write: req_write, size: req_size, sgn: req_signed,
                        err: req_err, addr: req_addr[AW-1:0], wdata: req_wdata};
               cnt       <= req_err ? 4'd0 : 4'(WAIT_CYCLES);
               req_ready <= 1'b0;
               state     <= S_WAIT;
            end
            S_WAIT: if (cnt != 4'd0) begin
               cnt <= cnt - 4'd1;
            end else begin
               resp_valid <= 1'b1;
               resp_err   <= cur.err;
               resp_rdata <= (cur.err || cur.write) ? 32'd0 : ld;
               if (!cur.err && cur.write) begin
                  case (cur.size)
                     2'b00: mem[cur.addr] <= cur.wdata[7:0];
                     2'b01: begin
                        mem[cur.addr] <= cur.wdata[15:8];
                        mem[a1]       <= cur.wdata[7:0];
                     end
                     default: begin
                        mem[cur.addr] <= cur.wdata[31:24];
                        mem[a1]       <= cur.wdata[23:16];
                        mem[a2]       <= cur.wdata[15:8];
                        mem[a3]       <= cur.wdata[7:0];
                     end
                  endcase
               end
               state <= S_RESP;
            end
            S_RESP: if (resp_ready) begin
               resp_valid <= 1'b0;
               req_ready  <= 1'b1;
               state      <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_data_mem_ctrl.sv
// Scoreboard bench for data_mem_ctrl: a byte-array model predicts each
// response at issue time; a monitor checks data, error flag and latency.
module tb_data_mem_ctrl;
   localparam int DEPTH = 64;
   localparam int WC    = 3;

   logic        clk = 0, reset = 0;
   logic        req_valid = 0, req_write = 0, req_signed = 0, resp_ready = 0;
   logic [1:0]  req_size = 0;
   logic [31:0] req_addr = 0, req_wdata = 0;
   logic        req_ready, resp_valid, resp_err;
   logic [31:0] resp_rdata;

   data_mem_ctrl #(.DEPTH(DEPTH), .WAIT_CYCLES(WC)) dut (
      .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
      .req_write(req_write), .req_size(req_size), .req_signed(req_signed),
      .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(resp_valid),
      .resp_ready(resp_ready), .resp_rdata(resp_rdata), .resp_err(resp_err)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int vectors = 0, fails = 0;

   typedef struct {
      logic [31:0] rdata;
      logic        err;
      int          due;
      int          hold;
   } exp_t;
   exp_t sb[$];

   logic [7:0] model [DEPTH];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      vectors++;
      if (act !== req) begin
         fails++;
         $display("FAIL %s: got %h, expected %h", name, act, req);
      end
   endtask

   function automatic void model_init();
      for (int i = 0; i < DEPTH; i++) model[i] = 8'(i);
   endfunction

   // Big-endian byte-array semantics straight from the access rules.
   function automatic void model_op(input logic wr, input logic [1:0] sz, input logic sg,
                                    input logic [31:0] ad, input logic [31:0] wd,
                                    output logic [31:0] rd, output logic er);
      longint n;
      n  = longint'(1) << sz;
      rd = 0;
      er = (sz == 2'b11) || (longint'(ad) % n != 0) || (longint'(ad) + n > DEPTH);
      if (!er) begin
         for (int j = 0; j < n; j++) begin
            if (wr) model[ad + j] = wd[8*(n-1-j) +: 8];
            else    rd = {rd[23:0], model[ad + j]};
         end
         if (!wr && sg && n < 4 && rd[8*n-1]) rd = rd | (32'hFFFF_FFFF << (8*n));
      end
   endfunction

   task automatic issue(input logic wr, input logic [1:0] sz, input logic sg,
                        input logic [31:0] ad, input logic [31:0] wd,
                        input int hold = 0, input bit track = 1);
      exp_t e;
      int   guard = 0;
      @(negedge clk);
      req_valid = 1; req_write = wr; req_size = sz; req_signed = sg;
      req_addr = ad; req_wdata = wd;
      while (!req_ready && guard < 200) begin
         @(negedge clk);
         guard++;
      end
      if (!req_ready) begin
         vectors++; fails++;
         $display("FAIL req_ready_timeout: req_ready=0, required 1");
         req_valid = 0;
         return;
      end
      model_op(wr, sz, sg, ad, wd, e.rdata, e.err);
      e.due  = cyc + 2 + (e.err ? 0 : WC);
      e.hold = hold;
      if (track) sb.push_back(e);
      @(posedge clk);
      #1 req_valid = 0;
   endtask

   task automatic drain();
      int guard = 0;
      while (sb.size() != 0 && guard < 500) begin
         @(negedge clk);
         guard++;
      end
      if (sb.size() != 0) begin
         vectors++; fails++;
         $display("FAIL drain_timeout: %0d responses outstanding, required 0", sb.size());
         sb.delete();
      end
   endtask

   bit seen = 0;
   int vcnt = 0;
   always @(negedge clk) begin
      if (!reset) begin
         seen = 0;
         resp_ready = 0;
      end else if (resp_valid) begin
         if (sb.size() == 0) begin
            vectors++; fails++;
            $display("FAIL unexpected_resp: resp_valid=1 rdata=%h, required no response", resp_rdata);
            resp_ready = 1;
         end else begin
            if (!seen) begin
               check("latency_cycle", cyc, sb[0].due);
               seen = 1;
               vcnt = 0;
            end
            check("resp_rdata", resp_rdata, sb[0].rdata);
            check("resp_err", resp_err, sb[0].err);
            check("req_ready_busy", req_ready, 0);
            vcnt++;
            if (vcnt <= sb[0].hold) resp_ready = 0;
            else if (sb[0].hold > 0) resp_ready = 1;
            else resp_ready = 1'($urandom_range(0, 1));
            if (resp_ready) begin
               void'(sb.pop_front());
               seen = 0;
            end
         end
      end else begin
         resp_ready = 1'($urandom_range(0, 1));
      end
   end

   initial begin
      #500_000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      logic [31:0] ad;
      logic [1:0]  sz;
      model_init();
      reset = 0;
      repeat (3) @(negedge clk);
      check("rst_resp_valid", resp_valid, 0);
      check("rst_resp_err", resp_err, 0);
      check("rst_resp_rdata", resp_rdata, 0);
      check("rst_req_ready", req_ready, 1);
      reset = 1;

      issue(0, 2'd2, 0, 4, 0);
      issue(0, 2'd0, 0, 63, 0);
      issue(1, 2'd2, 0, 8, 32'hDEAD_BEEF);
      issue(0, 2'd0, 1, 9, 0);
      issue(0, 2'd1, 0, 10, 0);
      issue(0, 2'd1, 1, 8, 0);
      issue(1, 2'd0, 0, 13, 32'h1234_5677);
      issue(0, 2'd2, 0, 12, 0);
      issue(0, 2'd2, 0, 2, 0);
      issue(1, 2'd1, 0, 5, 32'h0000_FFFF);
      issue(0, 2'd3, 0, 0, 0);
      issue(0, 2'd2, 0, 64, 0);
      issue(1, 2'd2, 0, 32'h8000_0000, 32'h1111_1111);
      issue(1, 2'd1, 0, 62, 32'h0000_ABCD);
      issue(0, 2'd2, 0, 4, 0);
      issue(0, 2'd2, 0, 4, 0, 5);
      issue(0, 2'd2, 0, 60, 0);

      for (int t = 0; t < 60; t++) begin
         ad = ($urandom_range(0, 9) == 0) ? $urandom : 32'($urandom_range(0, 67));
         sz = ($urandom_range(0, 7) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
         issue(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), ad, $urandom,
               ($urandom_range(0, 5) == 0) ? 3 : 0);
      end
      drain();

      // store aborted by reset mid-wait must never reach memory
      issue(1, 2'd2, 0, 0, 32'hAABB_CCDD, 0, 0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset = 0;
      #1;
      check("abort_resp_valid", resp_valid, 0);
      check("abort_req_ready", req_ready, 1);
      model_init();
      @(negedge clk);
      reset = 1;
      repeat (6) begin
         @(negedge clk);
         check("abort_no_resp", resp_valid, 0);
      end
      issue(0, 2'd2, 0, 0, 0);
      issue(0, 2'd2, 0, 60, 0);
      drain();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
      $finish;
   end
endmodule
